// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 stream demultiplexer: one valid/ready input steered by i_sel
// into four single-entry buffers, each with its own valid/ready drain port and drain counter.
module demux1to4_reg #(
    parameter int n  = 32,
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [1:0]    i_sel,
    input  logic [n-1:0]  i_data,
    output logic          o_valid0,
    output logic          o_valid1,
    output logic          o_valid2,
    output logic          o_valid3,
    input  logic          i_ready0,
    input  logic          i_ready1,
    input  logic          i_ready2,
    input  logic          i_ready3,
    output logic [n-1:0]  o_data0,
    output logic [n-1:0]  o_data1,
    output logic [n-1:0]  o_data2,
    output logic [n-1:0]  o_data3,
    output logic [CW-1:0] o_cnt0,
    output logic [CW-1:0] o_cnt1,
    output logic [CW-1:0] o_cnt2,
    output logic [CW-1:0] o_cnt3
);

    logic [3:0]           ready_vec;
    logic [3:0]           valid_vec;
    logic [3:0][n-1:0]    data_vec;
    logic [3:0][CW-1:0]   cnt_vec;
    logic                 accept;

    assign ready_vec = {i_ready3, i_ready2, i_ready1, i_ready0};

    // A full buffer still accepts when it drains on the same edge, giving 1 word/cycle per channel.
    assign o_ready = ~valid_vec[i_sel] | ready_vec[i_sel];
    assign accept  = i_valid & o_ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            logic          valid_q, valid_d;
            logic [n-1:0]  data_q,  data_d;
            logic [CW-1:0] cnt_q,   cnt_d;
            logic          drain;
            logic          take;

            always_comb begin
                drain   = valid_q & ready_vec[gi];
                take    = accept & (i_sel == 2'(gi));
                valid_d = take | (valid_q & ~drain);
                data_d  = take ? i_data : data_q;
                cnt_d   = drain ? cnt_q + CW'(1) : cnt_q;
            end

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    cnt_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign valid_vec[gi] = valid_q;
            assign data_vec[gi]  = data_q;
            assign cnt_vec[gi]   = cnt_q;
        end
    endgenerate

    assign o_valid0 = valid_vec[0];
    assign o_valid1 = valid_vec[1];
    assign o_valid2 = valid_vec[2];
    assign o_valid3 = valid_vec[3];
    assign o_data0  = data_vec[0];
    assign o_data1  = data_vec[1];
    assign o_data2  = data_vec[2];
    assign o_data3  = data_vec[3];
    assign o_cnt0   = cnt_vec[0];
    assign o_cnt1   = cnt_vec[1];
    assign o_cnt2   = cnt_vec[2];
    assign o_cnt3   = cnt_vec[3];

endmodule

// File: doc/demux1to4_reg.md
Name: demux1to4_reg

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4-to-1 select muxes in the datapath.
- Accepts one n-bit word per cycle on a valid/ready input and steers it, by i_sel, into one of four single-entry output buffers.
- Each buffer drains independently through its own valid/ready port.
- Keeps a per-channel wrapping count of words delivered, for debug and performance readout.

Parameters:
- n, 32, data width in bits.
- CW, 8, width of each per-channel delivered-word counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  upstream ready; a word transfers when i_valid & o_ready at a clock edge.
- i_sel  input  2  destination channel for i_data; sampled only when the word transfers.
- i_data  input  n  upstream word.
- o_valid0..o_valid3  output  1 each  channel k buffer holds a word.
- i_ready0..i_ready3  input  1 each  downstream k accepts; channel k drains when o_validk & i_readyk at a clock edge.
- o_data0..o_data3  output  n each  channel k buffered word; stable while o_validk=1 and not drained.
- o_cnt0..o_cnt3  output  CW each  number of words drained from channel k, modulo 2^CW.

Behaviour:
- Reset: i_rst=1 asynchronously clears all state, whatever the clock is doing.
  - o_valid0..3=0, o_data0..3=0, o_cnt0..3=0.
  - o_ready follows the combinational rule below and is therefore 1 during reset.
  - No transfer or drain is recorded while i_rst=1.
  - Reset mid-transfer discards every buffered word; no partial state survives.
- Per channel k, full_k = o_validk.
- Readiness:
  - o_ready = ~full[i_sel] | i_ready[i_sel].
  - This is a combinational path from i_sel, o_validk and i_readyk.
  - It does not depend on i_valid.
- Drain: when o_validk & i_readyk, o_cntk increments by 1 at that edge and wraps from 2^CW-1 to 0.
- Accept (i_valid & o_ready) with i_sel=k:
  - o_datak <= i_data and o_validk <= 1 at that edge.
  - Latency from input transfer to o_validk=1 is 1 cycle.
- Simultaneous drain and accept on the same channel k:
  - The new word replaces the old one: o_validk stays 1 and o_datak takes the new word.
  - o_cntk increments.
  - Full throughput is 1 word/cycle per channel.
- Drain on k without an accept on k: o_validk <= 0; o_datak holds its last value.
- Accept on k while another channel j drains: both occur in the same cycle, independently.
- Channel k full and not draining while i_sel=k:
  - o_ready=0; upstream stalls and no other channel is affected.
  - There is no head-of-line bypass: a word for a free channel behind the stalled word waits.
- i_valid=0: no state change except drains. i_sel and i_data are don't-care.
- Ordering: words to the same channel leave in acceptance order. Cross-channel order is not defined.
- No word is dropped or duplicated. Per channel, drained words equal accepted words minus the words still buffered.
- Downstream handshake rule: o_validk never deasserts without a drain, except on reset.

Test Plan:
- Reset then idle:
  - Assert i_rst mid-cycle with no clock edge -> o_valid0..3=0 and o_cnt0..3=0 immediately.
  - With i_valid=0 and i_ready*=0 -> o_ready=1.
- Single route:
  - i_valid=1, i_sel=2, i_data=32'hDEADBEEF, one cycle -> next cycle o_valid2=1, o_data2=32'hDEADBEEF, other o_valids=0.
  - Then i_ready2=1 for one cycle -> o_valid2=0 and o_cnt2=1.
- Backpressure:
  - Fill channel 1 with 32'h11 while i_ready1=0, then present 32'h22 on sel=1 -> o_ready=0, o_data1 stays 32'h11.
  - Raise i_ready1 -> 32'h22 accepted that edge, o_data1=32'h22, o_cnt1=1.
- Full-rate streaming:
  - 8 consecutive words 0..7 on sel=3 with i_ready3=1 -> o_ready=1 every cycle.
  - o_data3 shows 0..7 on consecutive cycles and o_cnt3=8 at the end.
- Interleave with a stall:
  - Channel 0 blocked (i_ready0=0) and holding a word; sequence sel=1,0,2.
  - -> sel=1 word accepted; upstream stalls on the sel=0 word, so the sel=2 word is not accepted until i_ready0 rises.
- Wrap and reset mid-operation:
  - CW=8, drain 257 words via channel 0 -> o_cnt0=1.
  - Assert i_rst with all four buffers full -> all o_valid=0 and counters=0 with no spurious drain counted.
